serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx_if.sv | 27 ++
 rtl/serial_tx.sv | 145 ++++++++++++++
 tb/tb_serial_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_if.sv
// Bus and status bundle for the serial transmitter: the master side writes
// bytes, the slave side (serial_tx) reports line and FIFO status.
interface serial_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic          we;
  logic [31:0]   wdata;
  logic          txd;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;

  modport master (
    output sel, we, wdata,
    input  txd, full, empty, count, busy, overflow
  );

  modport slave (
    input  sel, we, wdata,
    output txd, full, empty, count, busy, overflow
  );
endinterface

// File: rtl/serial_tx.sv
// UART transmitter (8N1, LSB first, idle high) fed by a byte FIFO.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, shift[0] on the line, LSB first
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;
  logic           overflow_q;

  logic           full, empty, push, pop, write_req, baud_tc;
  logic           unused_wdata;

  assign unused_wdata = ^bus.wdata[31:8];

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign write_req = bus.sel && bus.we;
  assign pop       = (state_q == IDLE) && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push      = write_req && (!full || pop);
  assign baud_tc   = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign bus.txd      = txd_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != IDLE) || !empty;
  assign bus.overflow = overflow_q;

  // State register plus the bit-timing datapath and the registered line output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic and datapath updates for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = '0;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
          shift_d = mem[head_q];
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
        else         baud_d  = baud_q + BW'(1);
      end
      DATA: begin
        bit_d = bit_q;
        if (baud_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_tc) state_d = IDLE;
        else         baud_d  = baud_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming state, so txd changes on the same edge as the state.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (write_req && !push) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= bus.wdata[7:0];
  end
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a frame-level reference model (byte queue
// plus position inside the current frame) is compared with the DUT every cycle,
// alongside literal expectations for the directed scenarios.
module tb_serial_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  serial_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes, and the byte on the wire with its cycle offset.
  logic [7:0] m_q[$];
  bit         m_active = 0;
  int         m_t      = 0;
  logic [7:0] m_cur    = '0;
  bit         m_ovf    = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_active = 0;
    m_t      = 0;
    m_ovf    = 0;
  endfunction

  // Frame layout: 1 start bit, 8 data bits LSB first, 1 stop bit, CPB cycles each.
  function automatic logic exp_txd();
    if (!m_active)      return 1'b1;
    if (m_t < CPB)      return 1'b0;
    if (m_t < 9 * CPB)  return m_cur[m_t / CPB - 1];
    return 1'b1;
  endfunction

  // Advance the model on each edge, then compare every output shortly after it.
  always @(posedge clk) begin
    bit wr, pop_now, push_now;
    logic [7:0] wd;
    wr = bus.sel && bus.we;
    wd = bus.wdata[7:0];
    if (rst) begin
      m_reset();
    end else begin
      pop_now  = !m_active && (m_q.size() > 0);
      push_now = wr && ((m_q.size() < DEPTH) || pop_now);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * CPB) m_active = 0;
      end else if (pop_now) begin
        m_cur    = m_q.pop_front();
        m_active = 1;
        m_t      = 0;
      end
      if (push_now) m_q.push_back(wd);
      if (wr && !push_now) m_ovf = 1;
    end
    #1;
    chk("txd",      32'(bus.txd),      32'(exp_txd()));
    chk("count",    32'(bus.count),    32'(m_q.size()));
    chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
    chk("empty",    32'(bus.empty),    32'(m_q.size() == 0));
    chk("busy",     32'(bus.busy),     32'(m_active || (m_q.size() > 0)));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  end

  task automatic step(input logic s, input logic w, input logic [31:0] d);
    @(negedge clk);
    bus.sel   = s;
    bus.we    = w;
    bus.wdata = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  // Write one word into an idle, empty transmitter and check the frame literally.
  task automatic frame_lit(input string nm, input logic [31:0] w, input bit bits[8]);
    logic e;
    step(1'b1, 1'b1, w);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i < CPB)           e = 1'b0;
      else if (i < 9 * CPB)  e = bits[(i - CPB) / CPB];
      else                   e = 1'b1;
      chk({nm, "_txd"}, 32'(bus.txd), 32'(e));
      if (i == 10 * CPB - 1) chk({nm, "_busy_last"}, 32'(bus.busy), 32'd1);
      step(1'b0, 1'b0, 32'h0);
    end
    chk({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({nm, "_txd_end"},  32'(bus.txd),  32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || m_q.size() > 0) && n < 1000) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("drain_timeout", 32'(n < 1000), 32'd1);
  endtask

  // Assert reset between edges and confirm the outputs react without a clock.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk({nm, "_txd"},   32'(bus.txd),      32'd1);
    chk({nm, "_count"}, 32'(bus.count),    32'd0);
    chk({nm, "_empty"}, 32'(bus.empty),    32'd1);
    chk({nm, "_busy"},  32'(bus.busy),     32'd0);
    chk({nm, "_ovf"},   32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit s, w;
    int dens;
    rst       = 1'b1;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_txd",   32'(bus.txd),      32'd1);
    chk("rst_count", 32'(bus.count),    32'd0);
    chk("rst_empty", 32'(bus.empty),    32'd1);
    chk("rst_full",  32'(bus.full),     32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    frame_lit("a5", 32'h0000_00A5, '{1, 0, 1, 0, 0, 1, 0, 1});
    frame_lit("3c", 32'hFFFF_FF3C, '{0, 0, 1, 1, 1, 1, 0, 0});

    // Back-to-back frames with a single idle cycle between them.
    step(1'b1, 1'b1, 32'h55);
    chk("b2b_count0", 32'(bus.count), 32'd1);
    step(1'b1, 1'b1, 32'hAA);
    chk("b2b_count1", 32'(bus.count), 32'd1);
    chk("b2b_start",  32'(bus.txd),   32'd0);
    idle(10 * CPB - 1);
    chk("b2b_stop",   32'(bus.txd),   32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("b2b_gap",    32'(bus.txd),   32'd1);
    chk("b2b_count2", 32'(bus.count), 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("b2b_start2", 32'(bus.txd),   32'd0);
    chk("b2b_count3", 32'(bus.count), 32'd0);
    drain();

    // Overflow: six writes into a four-entry FIFO while the first byte leaves.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1, 32'(i));
      if (i == 5) chk("ovf_full", 32'(bus.full), 32'd1);
    end
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count),    32'd4);
    drain();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset in the middle of data bit 3, then a clean frame afterwards.
    step(1'b1, 1'b1, 32'h5A);
    step(1'b1, 1'b1, 32'h66);
    n = 0;
    while (!(m_active && m_t == CPB + 3 * CPB + 1) && n < 100) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("mid_timeout", 32'(n < 100), 32'd1);
    async_reset("mid_rst");
    frame_lit("0f", 32'h0000_000F, '{1, 1, 1, 1, 0, 0, 0, 0});

    // Write while full on the very cycle the head is popped.
    step(1'b1, 1'b1, 32'h10);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'h10 + 32'(i));
    chk("pf_full", 32'(bus.full), 32'd1);
    n = 0;
    while (!(!m_active && m_q.size() > 0) && n < 100) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("pf_timeout", 32'(n < 100), 32'd1);
    step(1'b1, 1'b1, 32'h77);
    chk("pf_count", 32'(bus.count),    32'd4);
    chk("pf_ovf",   32'(bus.overflow), 32'd0);
    chk("pf_txd",   32'(bus.txd),      32'd0);
    drain();

    // Random traffic with varying write density, including lone sel or we.
    for (int ep = 0; ep < 6; ep++) begin
      dens = $urandom_range(0, 60);
      if (ep == 3) async_reset("rand_rst");
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 99) < dens) begin
          step(1'b1, 1'b1, $urandom);
        end else begin
          s = 1'($urandom);
          w = 1'($urandom);
          if (s && w) w = 1'b0;
          step(s, w, $urandom);
        end
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
